// File: rtl/cam_seq_pkg.sv
// Shared types and defaults for the OV7670 power/reset sequencer.
package cam_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PWDN     = 3'd1,
        RESET    = 3'd2,
        SETTLE   = 3'd3,
        CONFIG   = 3'd4,
        WAIT_CFG = 3'd5,
        READY    = 3'd6,
        ERROR    = 3'd7
    } seq_state_t;

    localparam int DEF_PWDN_TICKS   = 2;
    localparam int DEF_RST_TICKS    = 2;
    localparam int DEF_SETTLE_TICKS = 3;
    localparam int DEF_CFG_TIMEOUT  = 10;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_CNT_W        = 8;

    localparam int RETRY_W          = 2;
    localparam int RETRY_LIMIT      = (1 << RETRY_W) - 1;

endpackage

// File: rtl/tick_sync_edge.sv
// Two-flop synchroniser with rising-edge pulse for slow asynchronous inputs.
module tick_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    // sr[2] is only a history bit for edge detection, not a third sync stage.
    assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/cam_power_seq.sv
// OV7670 power-up/reset sequencer: drives PWDN/RESET timing from a slow tick,
// then requests SCCB configuration with timeout and bounded full re-sequencing.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | powered down, waiting for start
//   PWDN     | pwdn held high for PWDN_TICKS
//   RESET    | pwdn released, reset held low for RST_TICKS
//   SETTLE   | reset released, wait SETTLE_TICKS
//   CONFIG   | one-cycle cfg_start request
//   WAIT_CFG | wait for cfg_done, timeout after CFG_TIMEOUT ticks
//   READY    | camera configured
//   ERROR    | retries exhausted, camera held powered down
module cam_power_seq
    import cam_seq_pkg::*;
#(
    parameter int PWDN_TICKS   = DEF_PWDN_TICKS,
    parameter int RST_TICKS    = DEF_RST_TICKS,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS,
    parameter int CFG_TIMEOUT  = DEF_CFG_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_src,
    input  logic               start,
    input  logic               cfg_done,
    output logic               cam_pwdn,
    output logic               cam_reset,
    output logic               cfg_start,
    output logic               ready,
    output logic               error,
    output logic [RETRY_W-1:0] retries
);

    if (MAX_RETRY < 0 || MAX_RETRY > RETRY_LIMIT) begin : g_bad_retry
        $error("cam_power_seq: MAX_RETRY must be in 0..3");
    end
    if (PWDN_TICKS < 1 || RST_TICKS < 1 || SETTLE_TICKS < 1 || CFG_TIMEOUT < 1) begin : g_bad_ticks
        $error("cam_power_seq: tick parameters must be >= 1");
    end
    if (PWDN_TICKS > (1 << CNT_W) || RST_TICKS > (1 << CNT_W) ||
        SETTLE_TICKS > (1 << CNT_W) || CFG_TIMEOUT > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("cam_power_seq: CNT_W too narrow for tick parameters");
    end

    localparam logic [CNT_W-1:0]   PWDN_TC   = CNT_W'(PWDN_TICKS - 1);
    localparam logic [CNT_W-1:0]   RST_TC    = CNT_W'(RST_TICKS - 1);
    localparam logic [CNT_W-1:0]   SETTLE_TC = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0]   CFG_TC    = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    tick_sync_edge u_tick (
        .clk   (clk),
        .rst   (rst),
        .din   (tick_src),
        .pulse (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            retries   <= '0;
            cam_pwdn  <= 1'b1;
            cam_reset <= 1'b0;
            cfg_start <= 1'b0;
            ready     <= 1'b0;
            error     <= 1'b0;
        end else begin
            cfg_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PWDN;
                        cnt   <= '0;
                    end
                end
                PWDN: begin
                    if (tick) begin
                        if (cnt == PWDN_TC) begin
                            state    <= RESET;
                            cnt      <= '0;
                            cam_pwdn <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESET: begin
                    if (tick) begin
                        if (cnt == RST_TC) begin
                            state     <= SETTLE;
                            cnt       <= '0;
                            cam_reset <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (tick) begin
                        if (cnt == SETTLE_TC) begin
                            state <= CONFIG;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CONFIG: begin
                    state     <= WAIT_CFG;
                    cnt       <= '0;
                    cfg_start <= 1'b1;
                end
                WAIT_CFG: begin
                    // Completion takes priority over a coincident timeout tick.
                    if (cfg_done) begin
                        state <= READY;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else if (tick) begin
                        if (cnt == CFG_TC) begin
                            cnt       <= '0;
                            cam_pwdn  <= 1'b1;
                            cam_reset <= 1'b0;
                            if (retries == RETRY_MAX) begin
                                state <= ERROR;
                                error <= 1'b1;
                            end else begin
                                state   <= PWDN;
                                retries <= retries + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                READY, ERROR: begin
                    if (start) begin
                        state     <= PWDN;
                        cnt       <= '0;
                        retries   <= '0;
                        ready     <= 1'b0;
                        error     <= 1'b0;
                        cam_pwdn  <= 1'b1;
                        cam_reset <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_power_seq.sv
// Scoreboard bench for cam_power_seq: expected output edges are queued with
// their cycle stamps as stimulus is planned, and matched as the DUT toggles.
module tb_cam_power_seq;

    localparam int PER  = 40;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_src = 1'b0;
    logic       start = 1'b0;
    logic       cfg_done = 1'b0;
    logic       cam_pwdn, cam_reset, cfg_start, ready, error;
    logic [1:0] retries;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    int  n_cfg_pulse = 0;
    int  phase = 0;
    bit  tick_en = 1'b0;
    bit  mon_en = 1'b0;
    int  rise_cyc[$];

    typedef struct {
        int   sig;
        logic val;
        int   at;
    } ev_t;
    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [4:0] mon_cur;
    logic [4:0] prev = '0;
    logic       cs_d = 1'b0;

    cam_power_seq #(
        .PWDN_TICKS   (2),
        .RST_TICKS    (2),
        .SETTLE_TICKS (3),
        .CFG_TIMEOUT  (10),
        .MAX_RETRY    (3),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_src  (tick_src),
        .start     (start),
        .cfg_done  (cfg_done),
        .cam_pwdn  (cam_pwdn),
        .cam_reset (cam_reset),
        .cfg_start (cfg_start),
        .ready     (ready),
        .error     (error),
        .retries   (retries)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Divided-clock source: rises at a negedge, so the first sampling edge is cyc+1.
    always @(negedge clk) begin
        if (tick_en) begin
            if (phase == 0) begin
                tick_src = 1'b1;
                rise_cyc.push_back(cyc);
            end else if (phase == HALF) begin
                tick_src = 1'b0;
            end
            phase = (phase + 1) % PER;
        end else begin
            tick_src = 1'b0;
            phase = 0;
        end
    end

    always @(negedge clk) begin
        if (cfg_start === 1'b1 && cs_d === 1'b0) n_cfg_pulse++;
        cs_d = cfg_start;
    end

    // Signal index: 0 cam_pwdn, 1 cam_reset, 2 cfg_start, 3 ready, 4 error.
    always @(negedge clk) begin
        mon_cur = {error, ready, cfg_start, cam_reset, cam_pwdn};
        if (mon_en) begin
            for (int i = 0; i < 5; i++) begin
                if (mon_cur[i] !== prev[i]) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_edge: sig %0d -> %b at cyc %0d, required no edge", i, mon_cur[i], cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.sig != i || mon_e.val !== mon_cur[i] || mon_e.at != cyc) begin
                            n_fail++;
                            $display("FAIL edge: got sig %0d -> %b at cyc %0d, required sig %0d -> %b at cyc %0d",
                                     i, mon_cur[i], cyc, mon_e.sig, mon_e.val, mon_e.at);
                        end
                    end
                end
            end
        end
        prev = mon_cur;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int rc(input int r1, input int r);
        return r1 + PER * (r - 1);
    endfunction

    function automatic void push_ev(input int sig, input logic val, input int at);
        ev_t e;
        e.sig = sig;
        e.val = val;
        e.at  = at;
        exp_q.push_back(e);
    endfunction

    // One sequencing attempt k spans 17 source rises; kind: 0 retry timeout,
    // 1 final timeout to error, 2 cfg_done coincident with timeout, 3 open end.
    function automatic void push_attempt(input int r1, input int k, input int kind);
        int b;
        int t;
        b = 1 + 17 * k;
        t = rc(r1, b + 16) + 3;
        push_ev(0, 1'b0, rc(r1, b + 1) + 3);
        push_ev(1, 1'b1, rc(r1, b + 3) + 3);
        push_ev(2, 1'b1, rc(r1, b + 6) + 4);
        push_ev(2, 1'b0, rc(r1, b + 6) + 5);
        if (kind == 0 || kind == 1) begin
            push_ev(0, 1'b1, t);
            push_ev(1, 1'b0, t);
            if (kind == 1) push_ev(4, 1'b1, t);
        end else if (kind == 2) begin
            push_ev(3, 1'b1, t);
        end
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // from: 0 idle (no edges), 1 ready, 2 error.
    task automatic pulse_start(input int from);
        @(negedge clk);
        if (from == 1) begin
            push_ev(0, 1'b1, cyc + 1);
            push_ev(1, 1'b0, cyc + 1);
            push_ev(3, 1'b0, cyc + 1);
        end else if (from == 2) begin
            push_ev(4, 1'b0, cyc + 1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_ticks(output int r1);
        int guard;
        guard = 0;
        rise_cyc.delete();
        tick_en = 1'b1;
        while (rise_cyc.size() == 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (rise_cyc.size() == 0) begin
            $display("FAIL tick_gen: no source rise within 100 cycles");
            $fatal(1, "tick generator stalled");
        end
        r1 = rise_cyc[0];
    endtask

    task automatic stop_ticks();
        tick_en = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic nominal_run(input bit poke_settle, input string name);
        int r1;
        int cs;
        begin_ticks(r1);
        push_attempt(r1, 0, 3);
        cs = rc(r1, 7) + 4;
        push_ev(3, 1'b1, cs + 6);
        if (poke_settle) begin
            wait_until(rc(r1, 5) + 10);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_until(cs + 5);
        cfg_done = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        n_cmp++;
        if ({ready, error, cam_pwdn, cam_reset, retries} !== 6'b100100) begin
            n_fail++;
            $display("FAIL %s_ready: {rdy,err,pwdn,rst,retries}=%b, required 100100", name, {ready, error, cam_pwdn, cam_reset, retries});
        end
        stop_ticks();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d edges never seen, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({cam_pwdn, cam_reset, cfg_start, ready, error, retries} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_values: %b, required 1000000", {cam_pwdn, cam_reset, cfg_start, ready, error, retries});
        end
        rst = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cam_pwdn, cam_reset, cfg_start, ready, error, retries} !== 7'b1000000) begin
                n_fail++;
                $display("FAIL idle_values: %b at idle cycle %0d, required 1000000", {cam_pwdn, cam_reset, cfg_start, ready, error, retries}, i);
            end
        end
    endtask

    task automatic test_nominal(input int from);
        pulse_start(from);
        nominal_run(1'b0, "nominal");
    endtask

    task automatic test_retry();
        int r1;
        int p0;
        int t;
        pulse_start(1);
        p0 = n_cfg_pulse;
        begin_ticks(r1);
        for (int k = 0; k < 4; k++) push_attempt(r1, k, (k < 3) ? 0 : 1);
        for (int k = 0; k < 4; k++) begin
            t = rc(r1, 17 + 17 * k) + 3;
            wait_until(t);
            n_cmp++;
            if (retries !== 2'((k < 3) ? k + 1 : 3)) begin
                n_fail++;
                $display("FAIL retry_count: retries=%0d after timeout %0d, required %0d", retries, k + 1, (k < 3) ? k + 1 : 3);
            end
        end
        n_cmp++;
        if ({ready, error, cam_pwdn, cam_reset, retries} !== 6'b011011) begin
            n_fail++;
            $display("FAIL retry_error: {rdy,err,pwdn,rst,retries}=%b, required 011011", {ready, error, cam_pwdn, cam_reset, retries});
        end
        n_cmp++;
        if (n_cfg_pulse - p0 != 4) begin
            n_fail++;
            $display("FAIL retry_pulses: %0d cfg_start pulses, required 4", n_cfg_pulse - p0);
        end
        stop_ticks();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL retry_pending: %0d edges never seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_start_gating();
        pulse_start(2);
        n_cmp++;
        if ({error, retries} !== 3'b000) begin
            n_fail++;
            $display("FAIL error_clear: {err,retries}=%b, required 000", {error, retries});
        end
        nominal_run(1'b1, "gating");
    endtask

    task automatic test_simultaneous();
        int r1;
        int t;
        pulse_start(1);
        begin_ticks(r1);
        push_attempt(r1, 0, 0);
        push_attempt(r1, 1, 2);
        t = rc(r1, 34) + 3;
        wait_until(t - 1);
        cfg_done = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        n_cmp++;
        if ({ready, error, cam_pwdn, cam_reset, retries} !== 6'b100101) begin
            n_fail++;
            $display("FAIL simultaneous: {rdy,err,pwdn,rst,retries}=%b, required 100101", {ready, error, cam_pwdn, cam_reset, retries});
        end
        stop_ticks();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL simultaneous_pending: %0d edges never seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int r1;
        pulse_start(1);
        begin_ticks(r1);
        push_attempt(r1, 0, 0);
        push_attempt(r1, 1, 0);
        push_attempt(r1, 2, 3);
        wait_until(rc(r1, 41) + 10);
        n_cmp++;
        if (retries !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_retries: retries=%0d before reset, required 2", retries);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_pending: %0d edges never seen, required 0", exp_q.size());
        end
        mon_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cam_pwdn, cam_reset, cfg_start, ready, error, retries} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL mid_reset: %b, required 1000000", {cam_pwdn, cam_reset, cfg_start, ready, error, retries});
        end
        rst = 1'b1;
        stop_ticks();
        mon_en = 1'b1;
        test_nominal(0);
    endtask

    initial begin
        test_reset();
        test_nominal(0);
        test_retry();
        test_start_gating();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
